// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, BCD digit
// constants and helpers for digit saturation and prescaler sizing.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Bits needed to hold 0 .. period-1, i.e. ceil(log2(period)).
    function automatic int presc_width(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts enabled cycles and pulses tick for one cycle at
// terminal count (TICK_PERIOD-1), wrapping to 0 on the same edge.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int           W    = presc_width(TICK_PERIOD);
    localparam logic [W-1:0] TERM = W'(TICK_PERIOD - 1);

    logic [W-1:0] r_count;

    assign tick = enable && (r_count == TERM);

    // clear outranks enable so a restart always begins a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= tick ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with run/pause/load control and a done flag.
// Define BCD_COUNTDOWN_TIMER_BLINK_EN to blink the display enable while in DONE.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_PERIOD = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val1,
    input  logic [BCD_W-1:0] load_val0,
    output logic [BCD_W-1:0] hex1,
    output logic [BCD_W-1:0] hex0,
    output logic             en7Seg,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    state_t           r_state;
    logic [BCD_W-1:0] r_hex1;
    logic [BCD_W-1:0] r_hex0;
    logic             r_en;
    logic             r_done;

    state_t           w_state_nxt;
    logic [BCD_W-1:0] w_hex1_nxt;
    logic [BCD_W-1:0] w_hex0_nxt;
    logic             w_en_nxt;
    logic             w_done_nxt;
    logic             w_clear;
    logic             w_enable;
    logic             w_tick;
    logic             w_nonzero;
    logic             w_is_one;

    assign w_nonzero = (r_hex1 != '0) || (r_hex0 != '0);
    assign w_is_one  = (r_hex1 == '0) && (r_hex0 == BCD_W'(1));

`ifdef BCD_COUNTDOWN_TIMER_BLINK_EN
    assign w_enable = (r_state == ST_RUN) || (r_state == ST_DONE);
`else
    assign w_enable = (r_state == ST_RUN);
`endif

    tick_prescaler #(
        .TICK_PERIOD(TICK_PERIOD)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_enable),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hex1_nxt  = r_hex1;
        w_hex0_nxt  = r_hex0;
        w_en_nxt    = r_en;
        w_clear     = 1'b0;

        if (load) begin
            w_hex1_nxt  = bcd_sat(load_val1);
            w_hex0_nxt  = bcd_sat(load_val0);
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
            w_en_nxt    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_stop && w_nonzero) begin
                        w_state_nxt = ST_RUN;
                        w_clear     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        if (r_hex0 != '0) begin
                            w_hex0_nxt = r_hex0 - BCD_W'(1);
                        end else begin
                            w_hex0_nxt = BCD_MAX;
                            w_hex1_nxt = r_hex1 - BCD_W'(1);
                        end
                    end
                    // Reaching 00 takes precedence over a coincident pause.
                    if (w_tick && w_is_one) begin
                        w_state_nxt = ST_DONE;
                        w_clear     = 1'b1;
                    end else if (start_stop) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef BCD_COUNTDOWN_TIMER_BLINK_EN
                    if (w_tick) begin
                        w_en_nxt = ~r_en;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hex1  <= '0;
            r_hex0  <= '0;
            r_en    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hex1  <= w_hex1_nxt;
            r_hex0  <= w_hex0_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign hex1        = r_hex1;
    assign hex0        = r_hex0;
    assign en7Seg      = r_en;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_PERIOD=4: directed
// scenarios followed by random button traffic, checked every cycle.
module tb_bcd_countdown_timer;

    localparam int TP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val1 = 4'd0;
    logic [3:0] load_val0 = 4'd0;
    logic [3:0] hex1;
    logic [3:0] hex0;
    logic       en7Seg;
    logic       done;
    logic [1:0] dbg_state;

    bcd_countdown_timer #(
        .TICK_PERIOD(TP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_stop  (start_stop),
        .load        (load),
        .load_val1   (load_val1),
        .load_val0   (load_val0),
        .hex1        (hex1),
        .hex0        (hex0),
        .en7Seg      (en7Seg),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model: count held as a decimal number, elapsed running
    // cycles since the last step, state as 0=IDLE 1=RUN 2=PAUSE 3=DONE.
    int m_state = 0;
    int m_count = 0;
    int m_elapsed = 0;
    bit m_en = 1'b1;

    function automatic int sat9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_step(input bit r, input bit ss, input bit ld, input int v1, input int v0);
        if (r) begin
            m_state = 0; m_count = 0; m_elapsed = 0; m_en = 1'b1;
        end else if (ld) begin
            m_count = sat9(v1) * 10 + sat9(v0);
            m_state = 0; m_elapsed = 0; m_en = 1'b1;
        end else begin
            case (m_state)
                0: if (ss && m_count != 0) begin m_state = 1; m_elapsed = 0; end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == TP) begin
                        m_elapsed = 0;
                        m_count--;
                    end
                    if (m_count == 0) begin
                        m_state = 3; m_elapsed = 0;
                    end else if (ss) begin
                        m_state = 2;
                    end
                end
                2: if (ss) m_state = 1;
                default: begin
`ifdef BCD_COUNTDOWN_TIMER_BLINK_EN
                    m_elapsed++;
                    if (m_elapsed == TP) begin
                        m_elapsed = 0;
                        m_en = !m_en;
                    end
`endif
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit ss, input bit ld, input int v1, input int v0);
        @(negedge clk);
        rst        = r;
        start_stop = ss;
        load       = ld;
        load_val1  = 4'(v1);
        load_val0  = 4'(v0);
        model_step(r, ss, ld, v1, v0);
        exp_q.push_back({2'(m_state), 4'(m_count / 10), 4'(m_count % 10), m_en, 1'(m_state == 3)});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_load(input int v1, input int v0);
        step(1'b0, 1'b0, 1'b1, v1, v0);
    endtask

    task automatic press();
        step(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [11:0] e;
        logic [11:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {dbg_state, hex1, hex0, en7Seg, done};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t got st=%0d hex=%h%h en=%b done=%b want st=%0d hex=%h%h en=%b done=%b",
                             $time, a[11:10], a[9:6], a[5:2], a[1], a[0],
                             e[11:10], e[9:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500_000;
        $display("FAIL watchdog t=%0t got no_finish want finish", $time);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r, ss, ld;
        int v1, v0;

        // Reset held two cycles, then a start press with count 00 is ignored.
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        press();
        idle(3);

        // Load saturation.
        do_load(1, 15);
        idle(2);

        // Count with borrow from 10.
        do_load(1, 0);
        press();
        idle(10);

        // 01 reaches DONE after one period.
        do_load(0, 1);
        press();
        idle(6);

        // Pause after two running cycles, hold, resume.
        do_load(0, 5);
        press();
        idle(1);
        press();
        idle(10);
        press();
        idle(6);

        // load and start_stop together during RUN: load wins.
        do_load(2, 3);
        press();
        idle(2);
        step(1'b0, 1'b1, 1'b1, 4, 2);
        idle(8);

        // Reset mid-run.
        do_load(3, 3);
        press();
        idle(5);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        idle(3);

        // DONE then blink, then load at D+5.
        do_load(0, 1);
        press();
        idle(4);
        idle(5);
        do_load(0, 2);
        idle(2);

        // DONE ignores start_stop.
        press();
        idle(4);
        do_load(0, 1);
        press();
        idle(4);
        press();
        idle(10);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 29) == 0);
            ss = ($urandom_range(0, 5) == 0);
            v1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            v0 = int'($urandom_range(0, 15));
            step(r, ss, ld, v1, v0);
        end
        idle(2);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
